if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 92 +++++++++
 tb/tb_if_stage.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a RUN/HALT
// sequencer that stops fetching once the PC walks past the end of the image.
module if_stage #(
    parameter logic [6:0] PC_RESET  = 7'd0,
    parameter logic [6:0] LAST_ADDR = 7'd16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [6:0]  branch_target,
    input  logic        jump,
    input  logic [6:0]  jump_target,
    output logic [6:0]  readAddress,
    input  logic [31:0] instruction,
    output logic        if_id_valid,
    output logic [31:0] if_id_instruction,
    output logic [6:0]  if_id_pc_plus4,
    output logic        halted,
    output logic [15:0] fetch_count
);

    typedef enum logic {RUN, HALT} state_t;

    state_t      state_q, state_d;
    logic [6:0]  pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [6:0]  pcp4_q, pcp4_d;
    logic [15:0] cnt_q, cnt_d;
    logic [6:0]  pc_inc;

    // 7-bit add wraps naturally, so 124 + 4 lands on 0
    assign pc_inc = pc_q + 7'd4;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        instr_d = instr_q;
        pcp4_d  = pcp4_q;
        cnt_d   = cnt_q;
        if (branch_taken || jump) begin
            // branch wins over jump; targets are forced onto a word boundary
            pc_d    = (branch_taken ? branch_target : jump_target) & 7'b1111100;
            valid_d = 1'b0;
            instr_d = 32'd0;
            state_d = RUN;
        end else if (stall) begin
            // hold everything
        end else if (state_q == RUN) begin
            if (pc_q <= LAST_ADDR) begin
                instr_d = instruction;
                pcp4_d  = pc_inc;
                valid_d = 1'b1;
                pc_d    = pc_inc;
                cnt_d   = (cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
            end else begin
                state_d = HALT;
                valid_d = 1'b0;
            end
        end else begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            pc_q    <= PC_RESET;
            valid_q <= 1'b0;
            instr_q <= 32'd0;
            pcp4_q  <= 7'd0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            pcp4_q  <= pcp4_d;
            cnt_q   <= cnt_d;
        end
    end

    assign readAddress       = pc_q;
    assign if_id_valid       = valid_q;
    assign if_id_instruction = instr_q;
    assign if_id_pc_plus4    = pcp4_q;
    assign halted            = (state_q == HALT);
    assign fetch_count       = cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: the driver queues the expected post-edge view
// of the stage, a monitor pops and compares it one step after every rising edge.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [6:0]  branch_target = 7'd0;
    logic        jump = 1'b0;
    logic [6:0]  jump_target = 7'd0;
    logic [6:0]  readAddress;
    logic [31:0] instruction;
    logic        if_id_valid;
    logic [31:0] if_id_instruction;
    logic [6:0]  if_id_pc_plus4;
    logic        halted;
    logic [15:0] fetch_count;

    typedef struct packed {
        logic        v;
        logic [31:0] i;
        logic [6:0]  p;
        logic [6:0]  ra;
        logic        h;
        logic [15:0] c;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    if_stage dut (
        .clk(clk), .reset(reset), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .readAddress(readAddress), .instruction(instruction),
        .if_id_valid(if_id_valid), .if_id_instruction(if_id_instruction),
        .if_id_pc_plus4(if_id_pc_plus4), .halted(halted), .fetch_count(fetch_count)
    );

    // default 20-byte image
    always_comb begin
        case (readAddress)
            7'd0:    instruction = 32'h8C02000E;
            7'd4:    instruction = 32'h41290002;
            7'd8:    instruction = 32'h00623020;
            7'd12:   instruction = 32'h00C23822;
            7'd16:   instruction = 32'h01043020;
            default: instruction = 32'h00000000;
        endcase
    end

    function automatic exp_t mk(logic v, logic [31:0] i, logic [6:0] p,
                                logic [6:0] ra, logic h, logic [15:0] c);
        exp_t e;
        e.v = v; e.i = i; e.p = p; e.ra = ra; e.h = h; e.c = c;
        return e;
    endfunction

    task automatic chk(input string name, input int step, input logic [31:0] act,
                       input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h expected %h", name, step, act, req);
        end
    endtask

    int step_no = 0;
    always @(posedge clk) begin
        #1;
        if (sb_q.size() != 0) begin
            exp_t e;
            e = sb_q.pop_front();
            step_no++;
            chk("readAddress", step_no, 32'(readAddress), 32'(e.ra));
            chk("if_id_valid", step_no, 32'(if_id_valid), 32'(e.v));
            chk("if_id_instruction", step_no, if_id_instruction, e.i);
            chk("if_id_pc_plus4", step_no, 32'(if_id_pc_plus4), 32'(e.p));
            chk("halted", step_no, 32'(halted), 32'(e.h));
            chk("fetch_count", step_no, 32'(fetch_count), 32'(e.c));
        end
    end

    task automatic step(input logic r, input logic s, input logic bt, input logic [6:0] btg,
                        input logic j, input logic [6:0] jtg, input exp_t e);
        @(negedge clk);
        reset = r; stall = s; branch_taken = bt; branch_target = btg;
        jump = j; jump_target = jtg;
        sb_q.push_back(e);
    endtask

    task automatic run(input exp_t e);
        step(1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 7'd0, e);
    endtask

    initial begin
        // reset state
        step(1'b1, 1'b0, 1'b0, 7'd0, 1'b0, 7'd0, mk(0, 32'h0, 7'd0, 7'd0, 0, 16'd0));
        // free run through the image
        run(mk(1, 32'h8C02000E, 7'd4,  7'd4,  0, 16'd1));
        run(mk(1, 32'h41290002, 7'd8,  7'd8,  0, 16'd2));
        run(mk(1, 32'h00623020, 7'd12, 7'd12, 0, 16'd3));
        run(mk(1, 32'h00C23822, 7'd16, 7'd16, 0, 16'd4));
        run(mk(1, 32'h01043020, 7'd20, 7'd20, 0, 16'd5));
        // past the end: halt and stay halted, stall or not
        run(mk(0, 32'h01043020, 7'd20, 7'd20, 1, 16'd5));
        run(mk(0, 32'h01043020, 7'd20, 7'd20, 1, 16'd5));
        step(1'b0, 1'b1, 1'b0, 7'd0, 1'b0, 7'd0, mk(0, 32'h01043020, 7'd20, 7'd20, 1, 16'd5));
        // jump out of HALT
        step(1'b0, 1'b0, 1'b0, 7'd0, 1'b1, 7'd0, mk(0, 32'h0, 7'd20, 7'd0, 0, 16'd5));
        run(mk(1, 32'h8C02000E, 7'd4, 7'd4, 0, 16'd6));
        // three-cycle stall at PC=4
        repeat (3)
            step(1'b0, 1'b1, 1'b0, 7'd0, 1'b0, 7'd0, mk(1, 32'h8C02000E, 7'd4, 7'd4, 0, 16'd6));
        run(mk(1, 32'h41290002, 7'd8, 7'd8, 0, 16'd7));
        // branch + jump + stall at PC=8: aligned branch target wins
        step(1'b0, 1'b1, 1'b1, 7'd17, 1'b1, 7'd0, mk(0, 32'h0, 7'd8, 7'd16, 0, 16'd7));
        run(mk(1, 32'h01043020, 7'd20, 7'd20, 0, 16'd8));
        run(mk(0, 32'h01043020, 7'd20, 7'd20, 1, 16'd8));
        // unaligned jump target 7 -> 4
        step(1'b0, 1'b0, 1'b0, 7'd0, 1'b1, 7'd7, mk(0, 32'h0, 7'd20, 7'd4, 0, 16'd8));
        run(mk(1, 32'h41290002, 7'd8,  7'd8,  0, 16'd9));
        run(mk(1, 32'h00623020, 7'd12, 7'd12, 0, 16'd10));
        // reset during stall with pending branch at PC=12
        step(1'b1, 1'b1, 1'b1, 7'd16, 1'b0, 7'd0, mk(0, 32'h0, 7'd0, 7'd0, 0, 16'd0));
        run(mk(1, 32'h8C02000E, 7'd4, 7'd4, 0, 16'd1));

        begin
            int budget;
            budget = 10;
            while (sb_q.size() != 0 && budget > 0) begin
                @(posedge clk);
                budget--;
            end
            #2;
            if (sb_q.size() != 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
